// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one mux among 2**SELECT_LINES requesters
// Registered one-hot grant and binary select; optional per-owner hold limit with timeout pulse.
module mux_rr_arbiter #(
   parameter int SELECT_LINES = 4,
   parameter int MAX_HOLD     = 16,
   parameter int HOLD_BITS    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2**SELECT_LINES-1:0]    req,
   output logic [2**SELECT_LINES-1:0]    grant,
   output logic [SELECT_LINES-1:0]       select,
   output logic                          valid,
   output logic                          timeout
);
   localparam int N = 2**SELECT_LINES;
   localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [HOLD_BITS-1:0] HOLD_SAT  = '1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state, state_nx;
   logic [SELECT_LINES-1:0] ptr, ptr_nx, select_nx, win, idx;
   logic [HOLD_BITS-1:0]    hold_cnt, hold_nx;
   logic [N-1:0]            grant_nx, cand;
   logic                    found, owner_req, release_ev, limit_ev;

   assign owner_req  = req[select];
   assign release_ev = (state == GRANT) && !owner_req;
   assign limit_ev   = (MAX_HOLD != 0) && (state == GRANT) && owner_req && (hold_cnt == HOLD_LAST);
   assign timeout    = limit_ev;
   assign valid      = |grant;

   // While granting, the current owner is excluded so a handover always moves on.
   assign cand = (state == GRANT) ? (req & ~(N'(1) << select)) : req;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr + SELECT_LINES'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      select_nx = select;
      grant_nx  = grant;
      hold_nx   = hold_cnt;
      if (state == IDLE) begin
         if (found) begin
            state_nx  = GRANT;
            grant_nx  = N'(1) << win;
            select_nx = win;
            ptr_nx    = win + 1'b1;
            hold_nx   = '0;
         end
      end else if (release_ev || limit_ev) begin
         if (found) begin
            grant_nx  = N'(1) << win;
            select_nx = win;
            ptr_nx    = win + 1'b1;
            hold_nx   = '0;
         end else if (release_ev) begin
            state_nx = IDLE;
            grant_nx = '0;
            hold_nx  = '0;
         end else begin
            // Limit hit with no competitor: owner keeps the mux, pointer still advances.
            hold_nx = '0;
            ptr_nx  = select + 1'b1;
         end
      end else if (hold_cnt != HOLD_SAT) begin
         hold_nx = hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
         select   <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_nx;
         grant    <= grant_nx;
         select   <= select_nx;
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
// Per-step stimulus and expected outputs are queued together and compared after each edge.
module tb_mux_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic [15:0] grant;
   logic [3:0]  select;
   logic        valid, timeout;

   logic        rst_u = 1'b1;
   logic [15:0] req_u = '0;
   logic [15:0] grant_u;
   logic [3:0]  select_u;
   logic        valid_u, timeout_u;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic [21:0] exp;
   } step_t;
   step_t sb[$];

   logic [15:0] req_q = '0;
   logic        inv_en = 1'b0;

   mux_rr_arbiter #(.SELECT_LINES(4), .MAX_HOLD(4), .HOLD_BITS(8)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant),
      .select(select), .valid(valid), .timeout(timeout)
   );

   mux_rr_arbiter #(.SELECT_LINES(4), .MAX_HOLD(0), .HOLD_BITS(8)) dut_u (
      .clk(clk), .rst(rst_u), .req(req_u), .grant(grant_u),
      .select(select_u), .valid(valid_u), .timeout(timeout_u)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      req_q  <= req;
      inv_en <= 1'b1;
   end

   always @(negedge clk) begin
      if (inv_en) begin
         checks++;
         if (!$onehot0(grant) || (valid !== (|grant)) || (valid && grant[select] !== 1'b1)
             || ((grant & ~req_q) !== 16'h0000)) begin
            failures++;
            $display("FAIL invariant t=%0t got grant=%h select=%0d valid=%b req_q=%h required onehot0, valid==|grant, grant[select], grant within req",
                     $time, grant, select, valid, req_q);
         end
      end
   end

   function automatic void push(logic r, logic [15:0] q, logic [15:0] g, logic [3:0] s,
                                logic v, logic t);
      step_t e;
      e.rst = r;
      e.req = q;
      e.exp = {g, s, v, t};
      sb.push_back(e);
   endfunction

   task automatic test_reset();
      step_t e; int n = 0;
      push(1, 16'hFFFF, 16'h0000, 4'd0, 0, 0);
      push(1, 16'hFFFF, 16'h0000, 4'd0, 0, 0);
      push(0, 16'hFFFF, 16'h0001, 4'd0, 1, 0);
      push(0, 16'hFFFF, 16'h0001, 4'd0, 1, 0);
      push(0, 16'hFFFF, 16'h0001, 4'd0, 1, 0);
      push(0, 16'hFFFF, 16'h0001, 4'd0, 1, 1);
      push(0, 16'hFFFF, 16'h0002, 4'd1, 1, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL reset step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_single();
      step_t e; int n = 0;
      push(1, 16'h0000, 16'h0000, 4'd0, 0, 0);
      for (int j = 0; j < 3; j++) push(0, 16'h0020, 16'h0020, 4'd5, 1, 0);
      push(0, 16'h0000, 16'h0000, 4'd5, 0, 0);
      push(0, 16'h0000, 16'h0000, 4'd5, 0, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL single step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_rotation();
      step_t e; int n = 0;
      int owners[4] = '{0, 5, 10, 15};
      int o;
      push(1, 16'h0000, 16'h0000, 4'd0, 0, 0);
      for (int j = 0; j < 17; j++) begin
         o = owners[(j / 4) % 4];
         push(0, 16'h8421, 16'(1) << o, 4'(o), 1, (j % 4) == 3);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL rotation step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_sole();
      step_t e; int n = 0;
      push(1, 16'h0000, 16'h0000, 4'd0, 0, 0);
      for (int j = 0; j < 12; j++) push(0, 16'h0100, 16'h0100, 4'd8, 1, (j % 4) == 3);
      push(0, 16'h0000, 16'h0000, 4'd8, 0, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL sole step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      step_t e; int n = 0;
      push(1, 16'h0000, 16'h0000, 4'd0, 0, 0);
      push(0, 16'h0088, 16'h0008, 4'd3, 1, 0);
      push(0, 16'h0080, 16'h0080, 4'd7, 1, 0);
      push(0, 16'h0080, 16'h0080, 4'd7, 1, 0);
      push(0, 16'h0002, 16'h0002, 4'd1, 1, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL handover step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid();
      step_t e; int n = 0;
      push(1, 16'h0000, 16'h0000, 4'd0, 0, 0);
      push(0, 16'h0080, 16'h0080, 4'd7, 1, 0);
      push(0, 16'h0080, 16'h0080, 4'd7, 1, 0);
      push(1, 16'h0080, 16'h0000, 4'd0, 0, 0);
      push(0, 16'h0081, 16'h0001, 4'd0, 1, 0);
      push(0, 16'h0081, 16'h0001, 4'd0, 1, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst = e.rst; req = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant, select, valid, timeout} !== e.exp) begin
            failures++;
            $display("FAIL reset_mid step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant, select, valid, timeout}, e.exp);
         end
         n++;
      end
   endtask

   task automatic test_unlimited();
      step_t e; int n = 0;
      push(1, 16'h0003, 16'h0000, 4'd0, 0, 0);
      for (int j = 0; j < 300; j++) push(0, 16'h0003, 16'h0001, 4'd0, 1, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rst_u = e.rst; req_u = e.req;
         @(posedge clk); #1;
         checks++;
         if ({grant_u, select_u, valid_u, timeout_u} !== e.exp) begin
            failures++;
            $display("FAIL unlimited step %0d got {grant,select,valid,timeout}=%h required %h", n, {grant_u, select_u, valid_u, timeout_u}, e.exp);
         end
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_sole();
      test_back_to_back();
      test_reset_mid();
      test_unlimited();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
